inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 144 ++++++++++++++
 tb/tb_inst_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: fetch stage between the PC/ICache and the instruction buffer.
// Holds the fetch PC and issues one ICache request per fetch group. Only one
// request is outstanding at a time. The returned group is aligned and pushed
// to the buffer. A flush redirects fetch and drops any response still in flight.
// Build option: define FETCH_DUAL_EN to enable two-instruction groups.
// Without it, every group is a single instruction and slot 2 is tied to zero.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] flush_pc_i,
    input  logic        buffer_full_i,
    output logic        icache_req_o,
    output logic [31:0] icache_addr_o,
    input  logic        icache_valid_i,
    input  logic [31:0] icache_inst1_i,
    input  logic [31:0] icache_inst2_i,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] inst1_addr_o,
    output logic [31:0] inst2_addr_o,
    output logic        inst1_valid_o,
    output logic        inst2_valid_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] next_pc;
    logic        accept;

    // A response is forwarded only when it answers a live (unflushed) request.
    assign accept        = (state_q == REQ) && icache_valid_i && !flush;
    assign icache_req_o  = (state_q == REQ) || (state_q == DISCARD);
    assign icache_addr_o = req_addr_q;

    // Next fetch PC after the current group; a group never crosses an 8-byte line.
    always_comb begin
`ifdef FETCH_DUAL_EN
        next_pc = req_addr_q[2] ? (req_addr_q + 32'd4) : (req_addr_q + 32'd8);
`else
        next_pc = req_addr_q + 32'd4;
`endif
    end

    // Next-state logic for the FSM, fetch PC and request address.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    pc_d = flush_pc_i;
                end else if (!buffer_full_i) begin
                    req_addr_d = pc_q;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (flush) begin
                    pc_d = flush_pc_i;
                    // Response in the flush cycle is dropped here; otherwise wait it out.
                    state_d = icache_valid_i ? IDLE : DISCARD;
                end else if (icache_valid_i) begin
                    pc_d = next_pc;
                    if (!buffer_full_i) begin
                        req_addr_d = next_pc;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (flush) begin
                    pc_d = flush_pc_i;
                end
                if (icache_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Slot 1 output register: data/address hold, valid pulses for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst1_o       <= '0;
            inst1_addr_o  <= '0;
            inst1_valid_o <= 1'b0;
        end else begin
            inst1_valid_o <= accept;
            if (accept) begin
                inst1_o      <= icache_inst1_i;
                inst1_addr_o <= req_addr_q;
            end
        end
    end

`ifdef FETCH_DUAL_EN
    // Slot 2 output register: valid only when the group starts on an 8-byte boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst2_o       <= '0;
            inst2_addr_o  <= '0;
            inst2_valid_o <= 1'b0;
        end else begin
            inst2_valid_o <= accept && !req_addr_q[2];
            if (accept) begin
                inst2_o      <= icache_inst2_i;
                inst2_addr_o <= req_addr_q + 32'd4;
            end
        end
    end
`else
    // Single fetch: slot 2 is never used; its data input is deliberately ignored.
    logic unused_inst2;
    assign unused_inst2  = ^icache_inst2_i;
    assign inst2_o       = '0;
    assign inst2_addr_o  = '0;
    assign inst2_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. The cache response is driven by hand each cycle.
// Expected values come from the bench's own address/data model.
// Expectations adapt to FETCH_DUAL_EN when it is defined for the build.
module tb_inst_fetch;

`ifdef FETCH_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, buffer_full_i, icache_valid_i;
    logic [31:0] flush_pc_i, icache_inst1_i, icache_inst2_i;
    logic        icache_req_o, inst1_valid_o, inst2_valid_o;
    logic [31:0] icache_addr_o, inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    inst_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .flush_pc_i    (flush_pc_i),
        .buffer_full_i (buffer_full_i),
        .icache_req_o  (icache_req_o),
        .icache_addr_o (icache_addr_o),
        .icache_valid_i(icache_valid_i),
        .icache_inst1_i(icache_inst1_i),
        .icache_inst2_i(icache_inst2_i),
        .inst1_o       (inst1_o),
        .inst2_o       (inst2_o),
        .inst1_addr_o  (inst1_addr_o),
        .inst2_addr_o  (inst2_addr_o),
        .inst1_valid_o (inst1_valid_o),
        .inst2_valid_o (inst2_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] a);
        return (DUAL && !a[2]) ? a + 32'd8 : a + 32'd4;
    endfunction

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock; sample #1 after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a cache response for address a in the coming cycle.
    task automatic respond(input logic [31:0] a);
        icache_valid_i = 1'b1;
        icache_inst1_i = dat(a);
        icache_inst2_i = dat(a + 32'd4);
    endtask

    task automatic check_push(input string tag, input logic [31:0] a);
        logic two;
        two = DUAL && !a[2];
        check_eq({tag, " v1"}, {31'd0, inst1_valid_o}, 32'd1);
        check_eq({tag, " a1"}, inst1_addr_o, a);
        check_eq({tag, " d1"}, inst1_o, dat(a));
        check_eq({tag, " v2"}, {31'd0, inst2_valid_o}, {31'd0, two});
        if (two) begin
            check_eq({tag, " a2"}, inst2_addr_o, a + 32'd4);
            check_eq({tag, " d2"}, inst2_o, dat(a + 32'd4));
        end
    endtask

    task automatic check_nopush(input string tag);
        check_eq({tag, " v1"}, {31'd0, inst1_valid_o}, 32'd0);
        check_eq({tag, " v2"}, {31'd0, inst2_valid_o}, 32'd0);
    endtask

    logic [31:0] exp;

    initial begin
        rst = 1'b1; flush = 1'b0; flush_pc_i = '0; buffer_full_i = 1'b0;
        icache_valid_i = 1'b0; icache_inst1_i = '0; icache_inst2_i = '0;
        tick();
        tick();
        check_eq("rst req", {31'd0, icache_req_o}, 32'd0);
        check_eq("rst addr", icache_addr_o, 32'hBFC00000);
        check_eq("rst a1", inst1_addr_o, 32'd0);
        check_eq("rst d2", inst2_o, 32'd0);
        check_nopush("rst");

        // Back-to-back fetch with a single-cycle cache.
        rst = 1'b0;
        tick();
        exp = 32'hBFC00000;
        for (int i = 0; i < 3; i++) begin
            check_eq("seq req", {31'd0, icache_req_o}, 32'd1);
            check_eq("seq addr", icache_addr_o, exp);
            respond(exp);
            tick();
            check_push("seq", exp);
            exp = nxt(exp);
        end

        // Buffer full with a response in flight: pushed, then stall.
        buffer_full_i = 1'b1;
        respond(exp);
        tick();
        icache_valid_i = 1'b0;
        check_push("full", exp);
        check_eq("full req", {31'd0, icache_req_o}, 32'd0);
        exp = nxt(exp);
        tick();
        check_eq("full hold", {31'd0, icache_req_o}, 32'd0);
        check_nopush("full hold");
        buffer_full_i = 1'b0;
        tick();
        check_eq("resume req", {31'd0, icache_req_o}, 32'd1);
        check_eq("resume addr", icache_addr_o, exp);

        // Return to IDLE, then flush while idle.
        buffer_full_i = 1'b1;
        respond(exp);
        tick();
        icache_valid_i = 1'b0;
        buffer_full_i = 1'b0;
        flush = 1'b1;
        flush_pc_i = 32'h80000004;
        tick();
        flush = 1'b0;
        check_eq("idle flush req", {31'd0, icache_req_o}, 32'd0);
        check_nopush("idle flush");
        tick();
        check_eq("redir addr", icache_addr_o, 32'h80000004);
        respond(32'h80000004);
        tick();
        check_push("odd", 32'h80000004);
        check_eq("after odd", icache_addr_o, 32'h80000008);
        respond(32'h80000008);
        tick();
        icache_valid_i = 1'b0;
        check_push("even", 32'h80000008);
        exp = nxt(32'h80000008);

        // Flush in REQ, stale response three cycles later.
        flush = 1'b1;
        flush_pc_i = 32'h80001000;
        tick();
        flush = 1'b0;
        check_nopush("req flush");
        check_eq("discard req", {31'd0, icache_req_o}, 32'd1);
        tick();
        tick();
        respond(exp);
        tick();
        icache_valid_i = 1'b0;
        check_nopush("stale");
        tick();
        check_eq("post discard req", {31'd0, icache_req_o}, 32'd1);
        check_eq("post discard addr", icache_addr_o, 32'h80001000);

        // Flush coincident with the response.
        flush = 1'b1;
        flush_pc_i = 32'h80001800;
        respond(32'h80001000);
        tick();
        flush = 1'b0;
        icache_valid_i = 1'b0;
        check_nopush("coinc");
        check_eq("coinc idle", {31'd0, icache_req_o}, 32'd0);
        tick();
        check_eq("coinc addr", icache_addr_o, 32'h80001800);

        // Second flush while in DISCARD wins.
        flush = 1'b1;
        flush_pc_i = 32'h80003000;
        tick();
        flush_pc_i = 32'h80002000;
        tick();
        flush = 1'b0;
        check_nopush("discard flush");
        respond(32'h80001800);
        tick();
        icache_valid_i = 1'b0;
        check_nopush("discard drop");
        tick();
        check_eq("refetch addr", icache_addr_o, 32'h80002000);
        respond(32'h80002000);
        tick();
        icache_valid_i = 1'b0;
        check_push("refetch", 32'h80002000);

        // Reset clears the outputs.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst2 req", {31'd0, icache_req_o}, 32'd0);
        check_eq("rst2 a1", inst1_addr_o, 32'd0);
        check_eq("rst2 d1", inst1_o, 32'd0);
        check_nopush("rst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
